// File: rtl/rom_sdram_writer.sv
// Pairs loader bytes into 16-bit words and writes them to SDRAM via req/ack.
// Optional running byte checksum: define ROM_WRITER_CHECKSUM_EN.
module rom_sdram_writer #(
  parameter int FIFO_DEPTH = 4,
  parameter int ADDR_W = 22,
  parameter logic [ADDR_W-1:0] BASE_ADDR = '0
) (
  input  logic              wclk,
  input  logic              resetn,
  input  logic [7:0]        din,
  input  logic              din_valid,
  input  logic              loading,
  output logic              sdram_req,
  input  logic              sdram_ack,
  output logic [ADDR_W-1:0] sdram_addr,
  output logic [15:0]       sdram_wdata,
  output logic [1:0]        sdram_be,
  output logic              busy,
  output logic              done,
  output logic              overflow,
  output logic [23:0]       bytes_written,
  output logic [15:0]       checksum
);

  localparam int PW = $clog2(FIFO_DEPTH);

  typedef enum logic {S_IDLE, S_WAIT} st_t;

  st_t         state, state_nxt;
  logic        loading_q, fall_seen;
  logic        rise, fall;
  logic [7:0]  lo, lo_nxt;
  logic        pending, pend_nxt;
  logic        push, pop, load;
  logic [17:0] push_data;
  logic [17:0] mem [FIFO_DEPTH];
  logic [PW:0] wr_ptr, rd_ptr;
  logic        empty, full;

  assign rise  = loading & ~loading_q;
  assign fall  = ~loading & loading_q;
  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[PW] != rd_ptr[PW]) &&
                 (wr_ptr[PW-1:0] == rd_ptr[PW-1:0]);
  assign pop   = (state == S_WAIT) && sdram_ack;
  assign busy  = pending | ~empty | (state == S_WAIT);

  // A strobe in the falling cycle is paired first, then flushed if odd.
  always_comb begin
    push      = 1'b0;
    push_data = '0;
    lo_nxt    = lo;
    pend_nxt  = pending;
    if (din_valid) begin
      if (pending) begin
        push      = 1'b1;
        push_data = {2'b11, din, lo};
        pend_nxt  = 1'b0;
      end else if (fall) begin
        push      = 1'b1;
        push_data = {2'b01, 8'h00, din};
      end else begin
        lo_nxt   = din;
        pend_nxt = 1'b1;
      end
    end else if (fall && pending) begin
      push      = 1'b1;
      push_data = {2'b01, 8'h00, lo};
      pend_nxt  = 1'b0;
    end
  end

  always_ff @(posedge wclk) begin
    if (!resetn) begin
      loading_q <= 1'b0;
      fall_seen <= 1'b0;
      lo        <= '0;
      pending   <= 1'b0;
    end else begin
      loading_q <= loading;
      lo        <= lo_nxt;
      pending   <= pend_nxt;
      if (rise)
        fall_seen <= 1'b0;
      else if (fall)
        fall_seen <= 1'b1;
    end
  end

  always_ff @(posedge wclk) begin
    if (push && !full)
      mem[wr_ptr[PW-1:0]] <= push_data;
    else if (push && pop)
      mem[wr_ptr[PW-1:0]] <= push_data;
  end

  always_ff @(posedge wclk) begin
    if (!resetn) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      overflow <= 1'b0;
    end else begin
      if (push && (!full || pop))
        wr_ptr <= wr_ptr + 1'b1;
      if (pop)
        rd_ptr <= rd_ptr + 1'b1;
      if (push && full && !pop)
        overflow <= 1'b1;
    end
  end

  always_ff @(posedge wclk) begin
    if (!resetn)
      state <= S_IDLE;
    else
      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      S_IDLE: if (!empty) state_nxt = S_WAIT;
      S_WAIT: if (sdram_ack) state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    sdram_req = (state == S_WAIT);
    load      = (state == S_IDLE) && !empty;
  end

  always_ff @(posedge wclk) begin
    if (!resetn) begin
      sdram_wdata   <= '0;
      sdram_be      <= '0;
      sdram_addr    <= BASE_ADDR;
      bytes_written <= '0;
      done          <= 1'b0;
    end else begin
      if (load) begin
        sdram_wdata <= mem[rd_ptr[PW-1:0]][15:0];
        sdram_be    <= mem[rd_ptr[PW-1:0]][17:16];
      end
      if (rise) begin
        sdram_addr    <= BASE_ADDR;
        bytes_written <= '0;
      end else if (pop) begin
        sdram_addr    <= sdram_addr + 1'b1;
        bytes_written <= bytes_written + 24'(sdram_be[0]) +
                         24'(sdram_be[1]);
      end
      if (rise)
        done <= 1'b0;
      else if (!loading && fall_seen && !pending && empty &&
               state == S_IDLE)
        done <= 1'b1;
    end
  end

`ifdef ROM_WRITER_CHECKSUM_EN
  logic [15:0] csum;

  always_ff @(posedge wclk) begin
    if (!resetn)
      csum <= '0;
    else if (rise)
      csum <= din_valid ? {8'h00, din} : 16'h0000;
    else if (din_valid)
      csum <= csum + {8'h00, din};
  end

  assign checksum = csum;
`else
  assign checksum = 16'h0000;
`endif

endmodule

// File: tb/tb_rom_sdram_writer.sv
// Directed bench for rom_sdram_writer: pairing, flush, overflow,
// reset mid-request, address wrap and reload.
module tb_rom_sdram_writer;

`ifdef ROM_WRITER_CHECKSUM_EN
  localparam bit CS = 1'b1;
`else
  localparam bit CS = 1'b0;
`endif

  logic        wclk = 1'b0;
  logic        resetn;
  logic [7:0]  din;
  logic        din_valid;
  logic        loading;

  logic        m_req, m_ack, m_busy, m_done, m_ovf;
  logic [21:0] m_addr;
  logic [15:0] m_wdata, m_cs;
  logic [1:0]  m_be;
  logic [23:0] m_bw;

  logic        w_req, w_ack, w_busy, w_done, w_ovf;
  logic [3:0]  w_addr;
  logic [15:0] w_wdata, w_cs;
  logic [1:0]  w_be;
  logic [23:0] w_bw;

  logic        ack_en, ack_force;
  logic [39:0] log_m[$];
  logic [21:0] log_w[$];

  int checks = 0;
  int errors = 0;

  always #5 wclk = ~wclk;

  rom_sdram_writer u_main (
    .wclk(wclk), .resetn(resetn), .din(din), .din_valid(din_valid),
    .loading(loading), .sdram_req(m_req), .sdram_ack(m_ack),
    .sdram_addr(m_addr), .sdram_wdata(m_wdata), .sdram_be(m_be),
    .busy(m_busy), .done(m_done), .overflow(m_ovf),
    .bytes_written(m_bw), .checksum(m_cs)
  );

  rom_sdram_writer #(
    .FIFO_DEPTH(4), .ADDR_W(4), .BASE_ADDR(4'hF)
  ) u_wrap (
    .wclk(wclk), .resetn(resetn), .din(din), .din_valid(din_valid),
    .loading(loading), .sdram_req(w_req), .sdram_ack(w_ack),
    .sdram_addr(w_addr), .sdram_wdata(w_wdata), .sdram_be(w_be),
    .busy(w_busy), .done(w_done), .overflow(w_ovf),
    .bytes_written(w_bw), .checksum(w_cs)
  );

  initial begin
    m_ack = 1'b0;
    w_ack = 1'b0;
  end

  always @(posedge wclk) begin
    m_ack <= ack_force | (ack_en & m_req & ~m_ack);
    w_ack <= w_req & ~w_ack;
    if (resetn && m_req && m_ack)
      log_m.push_back({m_addr, m_wdata, m_be});
    if (resetn && w_req && w_ack)
      log_w.push_back({w_addr, w_wdata, w_be});
  end

  task automatic check(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic send(input logic [7:0] b);
    @(negedge wclk);
    din = b;
    din_valid = 1'b1;
    @(negedge wclk);
    din_valid = 1'b0;
  endtask

  task automatic wait_done(input string tag);
    for (int i = 0; i < 100; i++) begin
      if (m_done) break;
      @(negedge wclk);
    end
    check(tag, 64'(m_done), 64'd1);
  endtask

  initial begin
    resetn = 1'b0;
    din = 8'h00;
    din_valid = 1'b0;
    loading = 1'b0;
    ack_en = 1'b1;
    ack_force = 1'b0;
    repeat (3) @(negedge wclk);
    check("rst_req", 64'(m_req), 64'd0);
    check("rst_addr", 64'(m_addr), 64'd0);
    check("rst_data_be", 64'({m_wdata, m_be}), 64'd0);
    check("rst_flags", 64'({m_busy, m_done, m_ovf}), 64'd0);
    check("rst_bw_cs", 64'({m_bw, m_cs}), 64'd0);
    resetn = 1'b1;

    // four bytes, two full words
    @(negedge wclk);
    loading = 1'b1;
    send(8'h11); send(8'h22); send(8'h33); send(8'h44);
    loading = 1'b0;
    wait_done("t1_done");
    check("t1_nwr", 64'(log_m.size()), 64'd2);
    check("t1_wr0", 64'(log_m[0]), 64'({22'd0, 16'h2211, 2'b11}));
    check("t1_wr1", 64'(log_m[1]), 64'({22'd1, 16'h4433, 2'b11}));
    check("t1_bw", 64'(m_bw), 64'd4);
    check("t1_cs", 64'(m_cs), CS ? 64'h00AA : 64'h0);

    // second load, odd byte count flushed on fall
    log_m.delete();
    loading = 1'b1;
    @(negedge wclk);
    check("t2_rise", 64'({m_done, m_addr, m_bw}), 64'd0);
    send(8'hAA); send(8'hBB); send(8'hCC);
    loading = 1'b0;
    wait_done("t2_done");
    check("t2_nwr", 64'(log_m.size()), 64'd2);
    check("t2_wr0", 64'(log_m[0]), 64'({22'd0, 16'hBBAA, 2'b11}));
    check("t2_wr1", 64'(log_m[1]), 64'({22'd1, 16'h00CC, 2'b01}));
    check("t2_bw", 64'(m_bw), 64'd3);
    check("t2_cs", 64'(m_cs), CS ? 64'h0231 : 64'h0);

    // stall acks through a 40-byte stream
    log_m.delete();
    ack_en = 1'b0;
    loading = 1'b1;
    for (int i = 0; i < 40; i++) send(8'(i + 1));
    loading = 1'b0;
    check("t3_ovf", 64'(m_ovf), 64'd1);
    check("t3_stall", 64'(log_m.size()), 64'd0);
    ack_en = 1'b1;
    wait_done("t3_done");
    check("t3_lt20", 64'(log_m.size() < 20), 64'd1);
    check("t3_nwr", 64'(log_m.size()), 64'd4);
    for (int k = 0; k < 4; k++)
      if (k < log_m.size())
        check("t3_wr", 64'(log_m[k]),
              64'({22'(k), 8'(2 * k + 2), 8'(2 * k + 1), 2'b11}));
    check("t3_ovf_kept", 64'(m_ovf), 64'd1);
    check("t3_bw", 64'(m_bw), 64'd8);
    check("t3_cs", 64'(m_cs), CS ? 64'h0334 : 64'h0);

    // reset while a request is outstanding
    log_m.delete();
    ack_en = 1'b0;
    loading = 1'b1;
    @(negedge wclk);
    check("t4_ovf_reload", 64'(m_ovf), 64'd1);
    send(8'h55); send(8'h66);
    for (int i = 0; i < 20; i++) begin
      if (m_req) break;
      @(negedge wclk);
    end
    check("t4_req", 64'(m_req), 64'd1);
    resetn = 1'b0;
    loading = 1'b0;
    @(negedge wclk);
    check("t4_req_drop", 64'(m_req), 64'd0);
    resetn = 1'b1;
    ack_force = 1'b1;
    @(negedge wclk);
    ack_force = 1'b0;
    @(negedge wclk);
    @(negedge wclk);
    check("t4_idle", 64'({m_req, m_busy, m_done, m_ovf}), 64'd0);
    check("t4_addr", 64'(m_addr), 64'd0);
    check("t4_nolog", 64'(log_m.size()), 64'd0);

    // address wrap on the small instance, plus a fresh main load
    ack_en = 1'b1;
    log_m.delete();
    log_w.delete();
    @(negedge wclk);
    loading = 1'b1;
    send(8'h01); send(8'h02); send(8'h03); send(8'h04);
    loading = 1'b0;
    wait_done("t5_done");
    repeat (4) @(negedge wclk);
    check("t5_wnwr", 64'(log_w.size()), 64'd2);
    check("t5_wr0", 64'(log_w[0]), 64'({4'hF, 16'h0201, 2'b11}));
    check("t5_wr1", 64'(log_w[1]), 64'({4'h0, 16'h0403, 2'b11}));
    check("t5_main0", 64'(log_m[0]), 64'({22'd0, 16'h0201, 2'b11}));
    check("t5_bw", 64'(m_bw), 64'd4);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/rom_sdram_writer.md
Name: rom_sdram_writer

Overview:
- Downstream consumer of the ROM loader byte stream (`dout`/`dout_valid`/`loading`).
- Pairs bytes little-endian into 16-bit words, buffers them in a small FIFO, and issues level req/ack write requests to the SDRAM controller at consecutive word addresses.
- The loader has no backpressure, so this block absorbs stalls and flags any loss.
- Reports completion to the boot sequencer.

Parameters:
- FIFO_DEPTH, 4, word entries in the write FIFO; power of two, minimum 2.
- ADDR_W, 22, SDRAM word-address width.
- BASE_ADDR, 0, word address of the first ROM word.

Ports:
- wclk  input  1  system clock; all logic on its rising edge.
- resetn  input  1  synchronous active-low reset.
- din  input  8  ROM byte from the loader.
- din_valid  input  1  one-cycle strobe; din is valid this cycle.
- loading  input  1  high while the loader is streaming.
- sdram_req  output  1  write request; held high until acked.
- sdram_ack  input  1  one-cycle acknowledge from the SDRAM controller.
- sdram_addr  output  ADDR_W  word address of the current write.
- sdram_wdata  output  16  write data; byte 0 in [7:0].
- sdram_be  output  2  byte enables.
- busy  output  1  pending byte, FIFO non-empty, or request outstanding.
- done  output  1  load fully committed to SDRAM.
- overflow  output  1  sticky; a word was dropped on a full FIFO.
- bytes_written  output  24  count of bytes committed (acked).
- checksum  output  16  see Optional Feature.

Behaviour:
- Reset (resetn low at an edge), all outputs:
  - sdram_req=0, sdram_addr=BASE_ADDR, sdram_wdata=0, sdram_be=0.
  - busy=0, done=0, overflow=0, bytes_written=0, checksum=0.
  - FIFO emptied, pending-byte flag cleared, FSM=IDLE.
  - Reset mid-request drops req the next cycle; a late ack is ignored.
- Byte pairing:
  - Even-phase byte → stored in lo, pending=1.
  - Odd-phase byte → push {din, lo} with be=2'b11, pending=0.
  - Push occurs in the cycle after the second strobe.
- Flush:
  - loading falling edge (registered 1→0) with pending=1 → push {8'h00, lo} with be=2'b01, pending=0.
  - A din_valid in the same cycle loading falls is paired first, then flushed if still odd.
- FIFO:
  - Entry = {be, data}.
  - Push and pop in the same cycle are legal when full; the pop frees the slot.
  - Push on full without a pop → entry discarded, overflow=1 until reset.
- Write FSM:
  - IDLE: FIFO non-empty → load head into sdram_wdata/sdram_be, sdram_req=1, go WAIT.
  - WAIT: addr, data and be are held stable. On sdram_ack=1:
    - sdram_req=0, pop head.
    - sdram_addr += 1, wrapping mod 2^ADDR_W.
    - bytes_written += popcount(be).
    - go IDLE.
  - req is low for at least one cycle between writes.
  - Latency: a byte pair received at cycle t → req high at t+2 at the earliest, with an empty FIFO and FSM in IDLE.
  - An ack while in IDLE is ignored.
- done:
  - Set when all hold: loading low, a falling edge seen since reset, pending=0, FIFO empty, FSM IDLE.
  - Cleared by reset or a loading rising edge.
  - A new loading rise also resets sdram_addr to BASE_ADDR and bytes_written to 0; overflow is kept.
- busy = pending | FIFO non-empty | (FSM==WAIT).

Optional Feature:
- Macro: ROM_WRITER_CHECKSUM_EN.
- Defined:
  - checksum = 16-bit wrapping sum of every byte accepted from din, including dropped ones.
  - Updated the cycle after each strobe.
  - Cleared by reset and by a loading rising edge.
- Undefined: checksum tied to 16'h0000 and no adder is built.

Test Plan:
- Stream 11,22,33,44 (strobe every 2nd cycle), ack 1 cycle after each req → writes 0x2211@0 and 0x4433@1, be=11 both; bytes_written=4; done=1 after the second ack; checksum=0x00AA when enabled.
- Stream 3 bytes AA,BB,CC, then loading falls → writes 0xBBAA be=11, then 0x00CC be=01; bytes_written=3.
- Hold sdram_ack low for 60 cycles during a 40-byte stream → FIFO fills, overflow=1, fewer than 20 writes.
- Release ack after the stall → remaining FIFO entries drain in order; overflow stays 1.
- Assert resetn low while req=1 in WAIT, ack one cycle later → req=0, ack ignored, addr=BASE_ADDR, FIFO empty, done=0.
- BASE_ADDR=2^ADDR_W-1, 4 bytes → first write at all-ones, second at 0.
- Second load (loading rises again after done) → done clears, writes restart at BASE_ADDR, bytes_written restarts from 0.
